// File: rtl/fsm_seq_ctrl_param.sv
// Parametrised 14-state Moore sequence controller with a bounded loop counter,
// an optionally bounded burst counter, and a fault state that needs an explicit clear.
module fsm_seq_ctrl_param #(
  parameter int CNT_W     = 3,
  parameter int CNT_MAX   = 7,
  parameter int BURST_W   = 4,
  parameter int BURST_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             a,
  input  logic             b,
  output logic             s,
  output logic             bs,
  output logic             f,
  output logic [3:0]       st_o,
  output logic [CNT_W-1:0] cnt_o
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    INIT    = 4'd1,
    CHECK   = 4'd2,
    PULSE   = 4'd3,
    COUNT   = 4'd4,
    SAMPLE  = 4'd5,
    BRANCH  = 4'd6,
    PAIR    = 4'd7,
    BURST_A = 4'd8,
    BURST_B = 4'd9,
    WAIT    = 4'd10,
    ACK     = 4'd11,
    SIGNAL  = 4'd12,
    FAULT   = 4'd13
  } state_e;

  localparam logic [CNT_W-1:0]   CNT_LAST      = CNT_W'(CNT_MAX - 1);
  localparam logic [BURST_W-1:0] BURST_LAST    = BURST_W'(BURST_MAX - 1);
  localparam logic [BURST_W-1:0] BCNT_SAT      = {BURST_W{1'b1}};
  localparam bit                 BURST_BOUNDED = (BURST_MAX != 0);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BURST_W-1:0] bcnt_q, bcnt_d;
  logic               s_q, bs_q, f_q;

  function automatic logic dec_s(input state_e st_v);
    return (st_v == PULSE) || (st_v == SIGNAL);
  endfunction

  function automatic logic dec_bs(input state_e st_v);
    return (st_v == BURST_A) || (st_v == BURST_B);
  endfunction

  function automatic logic dec_f(input state_e st_v);
    return (st_v == FAULT);
  endfunction

  // Next-state and counter logic; clearing FAULT takes priority over the enable gate
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    if ((state_q == FAULT) && clr) begin
      state_d = IDLE;
      bcnt_d  = {BURST_W{1'b0}};
    end else if (en) begin
      case (state_q)
        IDLE:    state_d = INIT;
        INIT:    state_d = CHECK;
        CHECK:   state_d = b ? PULSE : COUNT;
        PULSE:   state_d = INIT;
        COUNT: begin
          if (cnt_q == CNT_LAST) begin
            state_d = WAIT;
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            state_d = SAMPLE;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        SAMPLE:  state_d = a ? PULSE : BRANCH;
        BRANCH:  state_d = a ? PAIR : BURST_A;
        PAIR:    state_d = (a && b) ? SAMPLE : FAULT;
        BURST_A: state_d = BURST_B;
        BURST_B: begin
          if (BURST_BOUNDED && (bcnt_q == BURST_LAST)) begin
            state_d = IDLE;
            bcnt_d  = {BURST_W{1'b0}};
          end else begin
            state_d = BURST_A;
            // Unbounded bursts saturate the counter instead of wrapping
            if (bcnt_q != BCNT_SAT) begin
              bcnt_d = bcnt_q + BURST_W'(1);
            end else begin
              bcnt_d = bcnt_q;
            end
          end
        end
        WAIT:    state_d = (a || b) ? ACK : COUNT;
        ACK:     state_d = SIGNAL;
        SIGNAL:  state_d = WAIT;
        FAULT:   state_d = FAULT;
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State, counters and flag outputs; flags are decoded from the next state so they line up with state_q
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      bcnt_q  <= {BURST_W{1'b0}};
      s_q     <= 1'b0;
      bs_q    <= 1'b0;
      f_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      s_q     <= dec_s(state_d);
      bs_q    <= dec_bs(state_d);
      f_q     <= dec_f(state_d);
    end
  end

  assign s     = s_q;
  assign bs    = bs_q;
  assign f     = f_q;
  assign st_o  = state_q;
  assign cnt_o = cnt_q;

endmodule

// File: tb/tb_fsm_seq_ctrl_param.sv
// Directed self-checking bench for fsm_seq_ctrl_param with default parameters.
module tb_fsm_seq_ctrl_param;

  logic       clk, rst, en, clr, a, b;
  logic       s, bs, f;
  logic [3:0] st_o;
  logic [2:0] cnt_o;

  int n_checks = 0;
  int n_pass   = 0;

  fsm_seq_ctrl_param #(
    .CNT_W(3), .CNT_MAX(7), .BURST_W(4), .BURST_MAX(4)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .a(a), .b(b),
    .s(s), .bs(bs), .f(f), .st_o(st_o), .cnt_o(cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; clr = 1'b0; a = 1'b0; b = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; clr = 1'b0; a = 1'b0; b = 1'b0;
    #1;
    n_checks++;
    if ({s, bs, f, st_o, cnt_o} !== 10'd0) $display("FAIL reset_async: got %b expected 0", {s, bs, f, st_o, cnt_o});
    else n_pass++;
    step();
    step();
    n_checks++;
    if ({s, bs, f, st_o, cnt_o} !== 10'd0) $display("FAIL reset_held: got %b expected 0", {s, bs, f, st_o, cnt_o});
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_pulse_loop();
    logic [3:0] exp_st [9] = '{4'd1, 4'd2, 4'd3, 4'd1, 4'd2, 4'd3, 4'd1, 4'd2, 4'd3};
    do_reset();
    en = 1'b1; b = 1'b1; a = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step();
      n_checks++;
      if ({st_o, s, bs, f} !== {exp_st[i], (exp_st[i] == 4'd3), 2'b00})
        $display("FAIL pulse_loop[%0d]: got st=%0d s=%b bs=%b f=%b expected st=%0d", i, st_o, s, bs, f, exp_st[i]);
      else n_pass++;
    end
  endtask

  task automatic test_count_loop();
    logic [7:0] exp_q [$];
    exp_q.push_back({4'd1, 3'd0, 1'b0});
    exp_q.push_back({4'd2, 3'd0, 1'b0});
    for (int k = 0; k < 6; k++) begin
      exp_q.push_back({4'd4, 3'(k),     1'b0});
      exp_q.push_back({4'd5, 3'(k + 1), 1'b0});
      exp_q.push_back({4'd3, 3'(k + 1), 1'b1});
      exp_q.push_back({4'd1, 3'(k + 1), 1'b0});
      exp_q.push_back({4'd2, 3'(k + 1), 1'b0});
    end
    exp_q.push_back({4'd4,  3'd6, 1'b0});
    exp_q.push_back({4'd10, 3'd0, 1'b0});
    exp_q.push_back({4'd11, 3'd0, 1'b0});
    exp_q.push_back({4'd12, 3'd0, 1'b1});
    exp_q.push_back({4'd10, 3'd0, 1'b0});
    do_reset();
    en = 1'b1; b = 1'b0; a = 1'b1;
    foreach (exp_q[i]) begin
      step();
      n_checks++;
      if ({st_o, cnt_o, s} !== exp_q[i])
        $display("FAIL count_loop[%0d]: got st=%0d cnt=%0d s=%b expected st=%0d cnt=%0d s=%b",
                 i, st_o, cnt_o, s, exp_q[i][7:4], exp_q[i][3:1], exp_q[i][0]);
      else n_pass++;
    end
  endtask

  task automatic test_burst();
    logic [3:0] pre_st [5] = '{4'd1, 4'd2, 4'd4, 4'd5, 4'd6};
    int run;
    do_reset();
    en = 1'b1; a = 1'b0; b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (st_o !== pre_st[i]) $display("FAIL burst_pre[%0d]: got st=%0d expected %0d", i, st_o, pre_st[i]);
      else n_pass++;
    end
    for (int i = 0; i < 8; i++) begin
      step();
      n_checks++;
      if ({st_o, bs} !== {((i % 2) == 0) ? 4'd8 : 4'd9, 1'b1})
        $display("FAIL burst_pair[%0d]: got st=%0d bs=%b expected st=%0d bs=1", i, st_o, bs, ((i % 2) == 0) ? 8 : 9);
      else n_pass++;
    end
    step();
    n_checks++;
    if ({st_o, bs} !== {4'd0, 1'b0}) $display("FAIL burst_end: got st=%0d bs=%b expected st=0 bs=0", st_o, bs);
    else n_pass++;
    // A second burst only lasts 8 cycles again if the burst counter was cleared
    for (int i = 0; i < 5; i++) step();
    run = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bs) run++;
      if (st_o == 4'd0) break;
    end
    n_checks++;
    if ((run != 8) || (st_o !== 4'd0)) $display("FAIL burst_repeat: got %0d bs cycles st=%0d expected 8 and st=0", run, st_o);
    else n_pass++;
  endtask

  task automatic test_fault();
    do_reset();
    en = 1'b1; a = 1'b0; b = 1'b0;
    for (int i = 0; i < 5; i++) step();
    n_checks++;
    if (st_o !== 4'd6) $display("FAIL fault_branch: got st=%0d expected 6", st_o);
    else n_pass++;
    a = 1'b1;
    step();
    b = 1'b0;
    step();
    n_checks++;
    if ({st_o, f, s, bs} !== {4'd13, 1'b1, 2'b00}) $display("FAIL fault_entry: got st=%0d f=%b expected st=13 f=1", st_o, f);
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      a  = 1'($urandom_range(1, 0));
      b  = 1'($urandom_range(1, 0));
      en = 1'($urandom_range(1, 0));
      step();
      n_checks++;
      if ({st_o, f} !== {4'd13, 1'b1}) $display("FAIL fault_hold[%0d]: got st=%0d f=%b expected st=13 f=1", i, st_o, f);
      else n_pass++;
    end
    en = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    n_checks++;
    if ({st_o, f} !== {4'd0, 1'b0}) $display("FAIL fault_clear: got st=%0d f=%b expected st=0 f=0", st_o, f);
    else n_pass++;
  endtask

  task automatic test_enable_hold();
    do_reset();
    en = 1'b1; b = 1'b0; a = 1'b1;
    for (int i = 0; i < 18; i++) step();
    n_checks++;
    if ({st_o, cnt_o} !== {4'd4, 3'd3}) $display("FAIL hold_setup: got st=%0d cnt=%0d expected st=4 cnt=3", st_o, cnt_o);
    else n_pass++;
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if ({st_o, cnt_o} !== {4'd4, 3'd3}) $display("FAIL hold_frozen[%0d]: got st=%0d cnt=%0d expected st=4 cnt=3", i, st_o, cnt_o);
      else n_pass++;
    end
    en = 1'b1;
    step();
    n_checks++;
    if ({st_o, cnt_o} !== {4'd5, 3'd4}) $display("FAIL hold_resume: got st=%0d cnt=%0d expected st=5 cnt=4", st_o, cnt_o);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    int run;
    do_reset();
    en = 1'b1; a = 1'b0; b = 1'b0;
    for (int i = 0; i < 7; i++) step();
    n_checks++;
    if ({st_o, cnt_o, bs} !== {4'd9, 3'd1, 1'b1}) $display("FAIL areset_setup: got st=%0d cnt=%0d bs=%b expected st=9 cnt=1 bs=1", st_o, cnt_o, bs);
    else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({st_o, cnt_o, bs} !== {4'd0, 3'd0, 1'b0}) $display("FAIL areset_mid: got st=%0d cnt=%0d bs=%b expected all 0", st_o, cnt_o, bs);
    else n_pass++;
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    run = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bs) run++;
      if (st_o == 4'd0) break;
    end
    n_checks++;
    if ((run != 8) || (st_o !== 4'd0)) $display("FAIL areset_burst: got %0d bs cycles st=%0d expected 8 and st=0", run, st_o);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_pulse_loop();
    test_count_loop();
    test_burst();
    test_fault();
    test_enable_hold();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
